viterbi_ctrl: RTL and testbench

- Control FSM that sequences the Viterbi tagging datapath: word fetch, the per-word emission×transition scoring sweep, HMM matrix writes, multiple-source resolution, max-probability selection, backtrace push and POS stack readout.
- Sits beside the datapath and drives every datapath control input. Consumes only the datapath status outputs plus a start pulse.
- Provides a busy/finished/error handshake to the top level.

---
 rtl/viterbi_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 tb/tb_viterbi_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_ctrl.sv
// ---------------------------------------------------------------------------
// viterbi_ctrl -- control FSM for the Viterbi POS-tagging datapath.
//
// The controller sequences one sentence through the datapath. For each word
// it fetches the key, then sweeps every (i,J) emission/transition pair while
// writing the HMM matrix. If needed it resolves multiple sources, and then
// commits the word. At end of line it selects the maximum probability,
// pushes the backtrace onto the POS stack and reads the stack back out.
//
// Every control output is a registered Moore output. Each one is decoded
// from the state (and first_word) the FSM is entering, so the outputs
// always reflect the current state.
//
// Optional feature, enabled by defining VITERBI_CTRL_WATCHDOG_EN:
//   A WDOG_W-bit dwell counter clears on every state change. If the counter
//   saturates in SCORE, TRACE or POP, the FSM is forced into ERROR.
//
// Ports:
//   clk, reset             rising-edge clock, async active-high reset
//   start                  sentence request (accepted in IDLE or ERROR only)
//   error, endline         datapath word-lookup error / end-of-sentence
//   multiple_source        more than one predecessor recorded
//   stack_empty, done      POS stack status
//   i, J                   emission / transition indices
//   key                    current key register value
//   increment_* .. reset_Stack_POS   datapath control strobes
//   busy                   high in every state except IDLE
//   finished               one-cycle pulse on successful completion
//   err_flag               sticky error, cleared by the next accepted start
// ---------------------------------------------------------------------------
module viterbi_ctrl #(
  parameter int POS_NUM      = 11,
  parameter int POS_NUM_BIT  = 4,
  parameter int WORD_NUM_BIT = 4,
  parameter int WDOG_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    error,
  input  logic                    endline,
  input  logic                    multiple_source,
  input  logic                    stack_empty,
  input  logic                    done,
  input  logic [POS_NUM_BIT-1:0]  i,
  input  logic [POS_NUM_BIT-1:0]  J,
  input  logic [WORD_NUM_BIT-1:0] key,
  output logic                    increment_enable_Words_control,
  output logic                    increment_enable_Emiss_control,
  output logic                    increment_enable_Transition_control,
  output logic                    reset_Transition_control,
  output logic                    reset_Emission_control,
  output logic                    RW_Key_reg,
  output logic                    decrement_enable,
  output logic                    RW_Pre_Posibility,
  output logic                    S_key_0,
  output logic                    S_key_1,
  output logic                    S_POS_HMM_0,
  output logic                    S_POS_HMM_1,
  output logic                    S_POS_HMM_2,
  output logic                    S_posibility_0,
  output logic                    S_posibility_1,
  output logic                    RW_HMM_matrix,
  output logic                    change_enable,
  output logic                    choose_output,
  output logic                    RW_Max_posibility,
  output logic                    RW_Stack_POS,
  output logic                    reset_Stack_POS,
  output logic                    busy,
  output logic                    finished,
  output logic                    err_flag
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_SCORE   = 4'd2,
    ST_RESOLVE = 4'd3,
    ST_COMMIT  = 4'd4,
    ST_MAXSEL  = 4'd5,
    ST_TRACE   = 4'd6,
    ST_POP     = 4'd7,
    ST_FINISH  = 4'd8,
    ST_ERROR   = 4'd9
  } state_t;

  typedef struct packed {
    logic inc_words;
    logic inc_emiss;
    logic inc_trans;
    logic rst_trans;
    logic rst_emiss;
    logic rw_key;
    logic dec_en;
    logic rw_pre;
    logic s_key_0;
    logic s_key_1;
    logic s_hmm_0;
    logic s_hmm_1;
    logic s_hmm_2;
    logic s_pos_0;
    logic s_pos_1;
    logic rw_hmm;
    logic change_en;
    logic choose_out;
    logic rw_max;
    logic rw_stack;
    logic rst_stack;
    logic busy;
    logic finished;
  } ctrl_t;

  localparam logic [POS_NUM_BIT-1:0]  LAST_IDX = POS_NUM_BIT'(POS_NUM - 1);
  localparam logic [WORD_NUM_BIT-1:0] KEY_ZERO = {WORD_NUM_BIT{1'b0}};

  // Reject parameter sets the index and watchdog widths cannot represent.
  if (POS_NUM > (2 ** POS_NUM_BIT)) begin : g_pos_num_check
    $error("viterbi_ctrl: POS_NUM does not fit in POS_NUM_BIT");
  end
  if (WDOG_W < 2) begin : g_wdog_w_check
    $error("viterbi_ctrl: WDOG_W must be at least 2");
  end

  // Moore decode: control strobes for a given state. In SCORE the
  // probability source depends on whether this is the first word.
  function automatic ctrl_t decode_ctrl(input state_t st, input logic fw);
    ctrl_t c;
    c = {$bits(ctrl_t){1'b0}};
    c.busy = (st != ST_IDLE);
    case (st)
      ST_IDLE: begin
        c.rst_trans = 1'b1;
        c.rst_emiss = 1'b1;
        c.rst_stack = 1'b1;
      end
      ST_FETCH: c.rw_key = 1'b1;
      ST_SCORE: begin
        c.rw_hmm    = 1'b1;
        c.s_key_1   = 1'b1;
        c.s_hmm_0   = 1'b1;
        c.inc_trans = 1'b1;
        c.s_pos_1   = fw;
        c.s_pos_0   = ~fw;
      end
      ST_RESOLVE: begin
        c.change_en = 1'b1;
        c.rw_max    = 1'b1;
        c.s_hmm_1   = 1'b1;
      end
      ST_COMMIT: begin
        c.rw_pre    = 1'b1;
        c.inc_words = 1'b1;
        c.rst_trans = 1'b1;
        c.rst_emiss = 1'b1;
      end
      ST_MAXSEL: c.rw_max = 1'b1;
      ST_TRACE: begin
        c.choose_out = 1'b1;
        c.s_key_0    = 1'b1;
        c.s_hmm_2    = 1'b1;
        c.rw_stack   = 1'b1;
        c.dec_en     = 1'b1;
      end
      ST_POP: c.busy = 1'b1;
      ST_FINISH: begin
        c.finished  = 1'b1;
        c.rst_stack = 1'b1;
      end
      ST_ERROR: c.busy = 1'b1;
      default: c = {$bits(ctrl_t){1'b0}};
    endcase
    return c;
  endfunction

  state_t state_r;
  state_t nom_next_s;
  state_t next_state_s;
  logic   first_word_r;
  logic   first_word_next_s;
  logic   start_accept_s;
  logic   err_flag_r;
  ctrl_t  ctrl_r;

  assign start_accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_ERROR));

  // Nominal next-state decision, before any watchdog override.
  always_comb begin
    nom_next_s = state_r;
    case (state_r)
      ST_IDLE:    nom_next_s = start ? ST_FETCH : ST_IDLE;
      ST_FETCH: begin
        if (error) begin
          nom_next_s = ST_ERROR;
        end else if (endline) begin
          nom_next_s = ST_MAXSEL;
        end else begin
          nom_next_s = ST_SCORE;
        end
      end
      ST_SCORE: begin
        if ((J == LAST_IDX) && (i == LAST_IDX)) begin
          nom_next_s = multiple_source ? ST_RESOLVE : ST_COMMIT;
        end else begin
          nom_next_s = ST_SCORE;
        end
      end
      ST_RESOLVE: nom_next_s = ST_COMMIT;
      ST_COMMIT:  nom_next_s = ST_FETCH;
      // first_word still set here means no word was committed: nothing to trace.
      ST_MAXSEL:  nom_next_s = first_word_r ? ST_FINISH : ST_TRACE;
      ST_TRACE:   nom_next_s = (key == KEY_ZERO) ? ST_POP : ST_TRACE;
      ST_POP:     nom_next_s = (done || stack_empty) ? ST_FINISH : ST_POP;
      ST_FINISH:  nom_next_s = ST_IDLE;
      ST_ERROR:   nom_next_s = start ? ST_FETCH : ST_ERROR;
      default:    nom_next_s = ST_IDLE;
    endcase
  end

`ifdef VITERBI_CTRL_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_cnt_r;
  logic              wdog_trip_s;

  assign wdog_trip_s = (&wdog_cnt_r) &&
                       ((state_r == ST_SCORE) || (state_r == ST_TRACE) || (state_r == ST_POP));
  assign next_state_s = wdog_trip_s ? ST_ERROR : nom_next_s;

  // Dwell counter: restarts on every state change, saturates otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (next_state_s != state_r) begin
      wdog_cnt_r <= {WDOG_W{1'b0}};
    end else if (!(&wdog_cnt_r)) begin
      wdog_cnt_r <= wdog_cnt_r + WDOG_W'(1'b1);
    end else begin
      wdog_cnt_r <= wdog_cnt_r;
    end
  end
`else
  assign next_state_s = nom_next_s;
`endif

  // first_word: set by an accepted start, cleared as the first word commits.
  always_comb begin
    if (start_accept_s) begin
      first_word_next_s = 1'b1;
    end else if (state_r == ST_COMMIT) begin
      first_word_next_s = 1'b0;
    end else begin
      first_word_next_s = first_word_r;
    end
  end

  // State, first_word and registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      first_word_r <= 1'b0;
      ctrl_r       <= decode_ctrl(ST_IDLE, 1'b0);
    end else begin
      state_r      <= next_state_s;
      first_word_r <= first_word_next_s;
      ctrl_r       <= decode_ctrl(next_state_s, first_word_next_s);
    end
  end

  // Sticky error flag: an accepted start clears it, and entering ERROR sets it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag_r <= 1'b0;
    end else if (start_accept_s) begin
      err_flag_r <= 1'b0;
    end else if (next_state_s == ST_ERROR) begin
      err_flag_r <= 1'b1;
    end else begin
      err_flag_r <= err_flag_r;
    end
  end

  assign increment_enable_Words_control      = ctrl_r.inc_words;
  assign increment_enable_Emiss_control      = ctrl_r.inc_emiss;
  assign increment_enable_Transition_control = ctrl_r.inc_trans;
  assign reset_Transition_control            = ctrl_r.rst_trans;
  assign reset_Emission_control              = ctrl_r.rst_emiss;
  assign RW_Key_reg                          = ctrl_r.rw_key;
  assign decrement_enable                    = ctrl_r.dec_en;
  assign RW_Pre_Posibility                   = ctrl_r.rw_pre;
  assign S_key_0                             = ctrl_r.s_key_0;
  assign S_key_1                             = ctrl_r.s_key_1;
  assign S_POS_HMM_0                         = ctrl_r.s_hmm_0;
  assign S_POS_HMM_1                         = ctrl_r.s_hmm_1;
  assign S_POS_HMM_2                         = ctrl_r.s_hmm_2;
  assign S_posibility_0                      = ctrl_r.s_pos_0;
  assign S_posibility_1                      = ctrl_r.s_pos_1;
  assign RW_HMM_matrix                       = ctrl_r.rw_hmm;
  assign change_enable                       = ctrl_r.change_en;
  assign choose_output                       = ctrl_r.choose_out;
  assign RW_Max_posibility                   = ctrl_r.rw_max;
  assign RW_Stack_POS                        = ctrl_r.rw_stack;
  assign reset_Stack_POS                     = ctrl_r.rst_stack;
  assign busy                                = ctrl_r.busy;
  assign finished                            = ctrl_r.finished;
  assign err_flag                            = err_flag_r;

  viterbi_ctrl_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .s_key_0     (S_key_0),
    .s_key_1     (S_key_1),
    .s_hmm_0     (S_POS_HMM_0),
    .s_hmm_1     (S_POS_HMM_1),
    .s_hmm_2     (S_POS_HMM_2),
    .s_pos_0     (S_posibility_0),
    .s_pos_1     (S_posibility_1)
  );

endmodule

// ---------------------------------------------------------------------------
// viterbi_ctrl_chk -- mutual-exclusion properties on the datapath mux selects.
// Ports: clk, reset, and the select outputs of viterbi_ctrl.
// ---------------------------------------------------------------------------
module viterbi_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic s_key_0,
  input logic s_key_1,
  input logic s_hmm_0,
  input logic s_hmm_1,
  input logic s_hmm_2,
  input logic s_pos_0,
  input logic s_pos_1
);

  a_key_excl: assert property (@(posedge clk) disable iff (reset)
    !(s_key_0 && s_key_1));

  a_hmm_excl: assert property (@(posedge clk) disable iff (reset)
    $onehot0({s_hmm_0, s_hmm_1, s_hmm_2}));

  a_pos_excl: assert property (@(posedge clk) disable iff (reset)
    !(s_pos_0 && s_pos_1));

endmodule

// File: tb/tb_viterbi_ctrl.sv
// ---------------------------------------------------------------------------
// tb_viterbi_ctrl -- directed self-checking bench for viterbi_ctrl.
// The bench drives i/J through the full 11x11 sweep and drives key
// downwards during the trace. Expected values are hand-derived from the
// controller's state sequence.
// ---------------------------------------------------------------------------
module tb_viterbi_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, error, endline, multiple_source, stack_empty, done;
  logic [3:0] i, J, key;
  logic       increment_enable_Words_control, increment_enable_Emiss_control;
  logic       increment_enable_Transition_control, reset_Transition_control;
  logic       reset_Emission_control, RW_Key_reg, decrement_enable, RW_Pre_Posibility;
  logic       S_key_0, S_key_1, S_POS_HMM_0, S_POS_HMM_1, S_POS_HMM_2;
  logic       S_posibility_0, S_posibility_1, RW_HMM_matrix, change_enable;
  logic       choose_output, RW_Max_posibility, RW_Stack_POS, reset_Stack_POS;
  logic       busy, finished, err_flag;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  viterbi_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .error(error), .endline(endline),
    .multiple_source(multiple_source), .stack_empty(stack_empty), .done(done),
    .i(i), .J(J), .key(key),
    .increment_enable_Words_control(increment_enable_Words_control),
    .increment_enable_Emiss_control(increment_enable_Emiss_control),
    .increment_enable_Transition_control(increment_enable_Transition_control),
    .reset_Transition_control(reset_Transition_control),
    .reset_Emission_control(reset_Emission_control),
    .RW_Key_reg(RW_Key_reg), .decrement_enable(decrement_enable),
    .RW_Pre_Posibility(RW_Pre_Posibility), .S_key_0(S_key_0), .S_key_1(S_key_1),
    .S_POS_HMM_0(S_POS_HMM_0), .S_POS_HMM_1(S_POS_HMM_1), .S_POS_HMM_2(S_POS_HMM_2),
    .S_posibility_0(S_posibility_0), .S_posibility_1(S_posibility_1),
    .RW_HMM_matrix(RW_HMM_matrix), .change_enable(change_enable),
    .choose_output(choose_output), .RW_Max_posibility(RW_Max_posibility),
    .RW_Stack_POS(RW_Stack_POS), .reset_Stack_POS(reset_Stack_POS),
    .busy(busy), .finished(finished), .err_flag(err_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called on the first SCORE cycle. It sweeps all 121 (i,J) pairs and then
  // walks through RESOLVE (when ms is set) and COMMIT. It returns in FETCH.
  task automatic score_word(input bit fw, input bit ms, input bit poke_start);
    int c_hmm, c_p1, c_p0, c_ok;
    c_hmm = 0; c_p1 = 0; c_p0 = 0; c_ok = 0;
    for (int n = 0; n < 121; n++) begin
      i = 4'(n / 11);
      J = 4'(n % 11);
      multiple_source = (n == 120) ? ms : 1'b0;
      start = poke_start && (n == 60);
      if (RW_HMM_matrix) c_hmm++;
      if (S_posibility_1) c_p1++;
      if (S_posibility_0) c_p0++;
      if (S_key_1 && S_POS_HMM_0 && increment_enable_Transition_control &&
          !increment_enable_Emiss_control && !S_key_0 && !S_POS_HMM_2) c_ok++;
      tick;
    end
    start = 1'b0; multiple_source = 1'b0; i = 4'd0; J = 4'd0;
    check("score_cycles", c_hmm, 121);
    check("score_p1", c_p1, fw ? 121 : 0);
    check("score_p0", c_p0, fw ? 0 : 121);
    check("score_ctl", c_ok, 121);
    if (ms) begin
      check("resolve_chg", change_enable, 1);
      check("resolve_max", RW_Max_posibility, 1);
      check("resolve_hmm1", S_POS_HMM_1, 1);
      tick;
    end
    check("commit_pre", RW_Pre_Posibility, 1);
    check("commit_words", increment_enable_Words_control, 1);
    check("commit_rst", {reset_Transition_control, reset_Emission_control}, 2'b11);
    check("commit_no_hmm", RW_HMM_matrix, 0);
    tick;
    check("fetch_key", RW_Key_reg, 1);
  endtask

  // Called on the first TRACE cycle. It counts the pushes while key counts
  // down to 0, then ends POP through done or stack_empty and returns in IDLE.
  task automatic trace_pop(input int start_key, input bit use_done);
    int pushes;
    logic [3:0] kv;
    pushes = 0;
    kv = 4'(start_key);
    for (int c = 0; c < 16; c++) begin
      key = kv;
      if (!(RW_Stack_POS && choose_output && S_key_0 && S_POS_HMM_2 && decrement_enable)) break;
      pushes++;
      tick;
      if (kv != 4'd0) kv = kv - 4'd1;
    end
    check("push_count", pushes, start_key + 1);
    check("pop_no_write", RW_Stack_POS, 0);
    check("pop_busy", busy, 1);
    tick;
    check("pop_hold_busy", busy, 1);
    check("pop_hold_fin", finished, 0);
    if (use_done) done = 1'b1; else stack_empty = 1'b1;
    tick;
    done = 1'b0; stack_empty = 1'b0;
    check("fin_pulse", finished, 1);
    check("fin_rst_stack", reset_Stack_POS, 1);
    tick;
    check("fin_once", finished, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; error = 1'b0; endline = 1'b0;
    multiple_source = 1'b0; stack_empty = 1'b0; done = 1'b0;
    i = 4'd0; J = 4'd0; key = 4'd0;
    tick; tick;
    check("rst_busy", busy, 0);
    check("rst_finished", finished, 0);
    check("rst_err", err_flag, 0);
    check("rst_resets", {reset_Transition_control, reset_Emission_control, reset_Stack_POS}, 3'b111);
    check("rst_hmm", RW_HMM_matrix, 0);
    check("rst_key", RW_Key_reg, 0);
    reset = 1'b0;
    tick;
    check("idle_hold", busy, 0);

    // Error in FETCH: ERROR two cycles after start, sticky until the next start.
    start = 1'b1; tick; start = 1'b0;
    check("err_fetch_key", RW_Key_reg, 1);
    check("err_fetch_busy", busy, 1);
    error = 1'b1; tick; error = 1'b0;
    check("err_flag_set", err_flag, 1);
    check("err_busy", busy, 1);
    check("err_no_key", RW_Key_reg, 0);
    check("err_no_rst", reset_Stack_POS, 0);
    tick; tick;
    check("err_flag_hold", err_flag, 1);
    check("err_no_hmm", RW_HMM_matrix, 0);
    start = 1'b1; tick; start = 1'b0;
    check("err_restart_clr", err_flag, 0);
    check("err_restart_key", RW_Key_reg, 1);
    // Empty sentence: MAXSEL goes straight to FINISH with no push.
    endline = 1'b1; tick; endline = 1'b0;
    check("empty_maxsel", RW_Max_posibility, 1);
    tick;
    check("empty_finish", finished, 1);
    check("empty_no_push", RW_Stack_POS, 0);
    tick;
    check("empty_idle", busy, 0);

    // One word, then endline; a start pulse mid-SCORE must be dropped.
    start = 1'b1; tick; start = 1'b0;
    tick;
    score_word(1'b1, 1'b0, 1'b1);
    endline = 1'b1; tick; endline = 1'b0;
    check("w1_maxsel", RW_Max_posibility, 1);
    tick;
    trace_pop(0, 1'b0);

    // Two words with multiple_source at the end of word 2, then key 2 -> 0.
    start = 1'b1; tick; start = 1'b0;
    tick;
    score_word(1'b1, 1'b0, 1'b0);
    tick;
    score_word(1'b0, 1'b1, 1'b0);
    endline = 1'b1; tick; endline = 1'b0;
    check("w2_maxsel", RW_Max_posibility, 1);
    tick;
    trace_pop(2, 1'b1);

    // Reset asserted mid-SCORE drops to IDLE immediately.
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    check("mid_score", RW_HMM_matrix, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_resets", {reset_Transition_control, reset_Emission_control, reset_Stack_POS}, 3'b111);
    check("mid_rst_hmm", RW_HMM_matrix, 0);
    tick;
    reset = 1'b0;
    tick;
    check("mid_rst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
